if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
Fetch-stage sequencer. It owns the PC and issues one instruction-memory request at a time. It drives the returned instruction through the IF mini decoder and hands the instruction to ID over a valid/ready handshake. Next PC comes from mini-decode results: jal taken, static backward-taken branch prediction, jalr via an RF read with hazard stall. EX redirects override everything.

Parameters:
XLEN, 32, data/address width (matches `XLEN)
INSTR_WIDTH, 32, instruction width (matches `INSTR_WIDTH)
RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  synchronous reset, active-low
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  imem accepts request
imem_req_addr_o  out  XLEN  fetch address
imem_rsp_valid_i  in  1  instruction returned (latency >=1 after accept)
imem_rsp_instr_i  in  INSTR_WIDTH  returned instruction
mini_dec_instr_o  out  INSTR_WIDTH  buffered instruction to mini decoder
mini_dec_jal_i / mini_dec_jalr_i / mini_dec_branch_i  in  1 each  decode flags
mini_dec_jalr_rs1_idx_i  in  5  jalr base register
mini_dec_imm_i  in  XLEN  sign-extended immediate
jalr_rs1_idx_o  out  5  RF read index for jalr base
jalr_rs1_rdata_i  in  XLEN  RF read data (combinational)
jalr_rs1_busy_i  in  1  scoreboard: jalr_rs1_idx_o has pending write
ex_redirect_i  in  1  mispredict/trap redirect
ex_redirect_pc_i  in  XLEN  redirect target
if_valid_o  out  1  instruction valid to ID
id_ready_i  in  1  ID accepts
if_instr_o  out  INSTR_WIDTH  instruction to ID
if_pc_o  out  XLEN  PC of if_instr_o
if_pred_taken_o  out  1  fetch predicted taken (jal, jalr, backward branch)

Behaviour:
- Sync reset, active-low: state=IDLE, pc_q=RESET_PC, instr buffer=0. All valid outputs 0; data outputs 0.
- States: IDLE, REQ, WAIT, HOLD, JALR_WAIT, DRAIN.
- IDLE: one cycle, then REQ. First imem_req_valid_o=1 on the 2nd clock after rst_n_i rises.
- REQ: imem_req_valid_o=1, addr=pc_q. Hold valid and addr stable until ready. Accept -> WAIT.
- WAIT: on imem_rsp_valid_i, latch instr into buffer -> HOLD.
- HOLD: if_valid_o=1, if_instr_o=buffer, if_pc_o=pc_q. mini_dec_instr_o always = buffer.
- Handoff is when if_valid_o && id_ready_i. Next PC, all arithmetic modulo 2^XLEN:
  - jal: pc_q+imm, pred=1.
  - branch with imm[XLEN-1]=1: pc_q+imm, pred=1.
  - branch with imm[XLEN-1]=0: pc_q+4, pred=0.
  - jalr: see below, pred=1.
  - otherwise: pc_q+4, pred=0.
- Non-jalr handoff: pc_q<=npc, go to REQ.
- jalr at handoff:
  - If idx==0, or busy=0: npc=(rdata+imm) with bit0 cleared (idx 0 uses rdata=0, busy ignored) -> REQ.
  - Else latch idx and imm -> JALR_WAIT.
- JALR_WAIT: jalr_rs1_idx_o = latched idx. In the first cycle busy=0, pc_q<=(rdata+imm_latched)&~1 -> REQ. No request is issued while waiting.
- jalr_rs1_idx_o = mini_dec_jalr_rs1_idx_i outside JALR_WAIT.
- No alignment checks except the jalr bit0 clear. EX handles misaligned targets.
- if_pred_taken_o is valid only with if_valid_o; otherwise 0.
- ex_redirect_i has the highest priority in every state. pc_q<=ex_redirect_pc_i, if_valid_o forced 0 that cycle, and the handoff is suppressed. Next state:
  - WAIT with no rsp this cycle, or REQ accepted this cycle -> DRAIN.
  - WAIT with rsp this cycle -> REQ, response dropped.
  - All other states -> REQ.
- DRAIN: the next imem_rsp_valid_i is discarded -> REQ. A second redirect in DRAIN updates pc_q and stays in DRAIN.
- At most one outstanding imem request at any time.
- Reset asserted mid-operation returns to the reset state next edge regardless of outstanding request. A stale response after reset is ignored: only WAIT/DRAIN consume responses.

Test Plan:
- Reset release, imem ready=1, latency 1, instr NOP 32'h00000013, id_ready=1 -> req addrs 8000_0000, 8000_0004, 8000_0008. if_pred_taken_o=0. First req on 2nd cycle after reset.
- jal imm=+16 at 8000_0000 -> if_pred_taken_o=1, next req addr 8000_0010. Backward branch imm=-8 at 8000_0010 -> next req 8000_0008, pred=1. Forward branch imm=+8 -> pc+4, pred=0.
- jalr rs1=x5, imm=3, rdata=8000_1000, busy=1 for 3 cycles -> no req during wait, then req addr 8000_1002. jalr x0 imm=0x101 -> req 0000_0100 with no stall.
- ex_redirect to 8000_2000 while in WAIT, response arrives 2 cycles later with 32'hDEADBEEF -> response not presented to ID, next req 8000_2000.
- id_ready=0 for 4 cycles in HOLD -> if_valid_o, if_instr_o, if_pc_o stable, no new req. Redirect in the same cycle as id_ready=1 -> no handoff, req to redirect PC.
- rst_n_i low while in WAIT -> next cycle all valids 0, then req at RESET_PC. The late response is ignored.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: fetch-stage sequencer owning the PC, one imem request in flight, IF->ID handshake.
// Ports:
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   imem_req_*_o / imem_req_ready_i fetch request channel (addr = pc_q while in REQ)
//   imem_rsp_valid_i/instr_i       returned instruction, latched into the instruction buffer
//   mini_dec_*                     buffered instruction out, decode flags/immediate back in
//   jalr_rs1_*                     register-file read port and scoreboard busy for the jalr base
//   ex_redirect_*                  EX redirect, overrides everything
//   if_*_o / id_ready_i            instruction, PC and prediction handed to ID
module if_fetch_ctrl #(
  parameter int XLEN = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  output logic                   imem_req_valid_o,
  input  logic                   imem_req_ready_i,
  output logic [XLEN-1:0]        imem_req_addr_o,
  input  logic                   imem_rsp_valid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_instr_i,
  output logic [INSTR_WIDTH-1:0] mini_dec_instr_o,
  input  logic                   mini_dec_jal_i,
  input  logic                   mini_dec_jalr_i,
  input  logic                   mini_dec_branch_i,
  input  logic [4:0]             mini_dec_jalr_rs1_idx_i,
  input  logic [XLEN-1:0]        mini_dec_imm_i,
  output logic [4:0]             jalr_rs1_idx_o,
  input  logic [XLEN-1:0]        jalr_rs1_rdata_i,
  input  logic                   jalr_rs1_busy_i,
  input  logic                   ex_redirect_i,
  input  logic [XLEN-1:0]        ex_redirect_pc_i,
  output logic                   if_valid_o,
  input  logic                   id_ready_i,
  output logic [INSTR_WIDTH-1:0] if_instr_o,
  output logic [XLEN-1:0]        if_pc_o,
  output logic                   if_pred_taken_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, JALR_WAIT, DRAIN} state_t;
  state_t state_q;
  logic [XLEN-1:0] pc_q, imm_q, jalr_base, jalr_tgt_d, wait_tgt_d, npc_d;
  logic [INSTR_WIDTH-1:0] buf_q;
  logic [4:0] idx_q;
  logic pred, jalr_stall, handoff;
  always_comb begin
    jalr_base = mini_dec_jalr_rs1_idx_i == 5'd0 ? '0 : jalr_rs1_rdata_i;
    jalr_tgt_d = (jalr_base + mini_dec_imm_i) & ~XLEN'(1);
    wait_tgt_d = (jalr_rs1_rdata_i + imm_q) & ~XLEN'(1);
    pred = mini_dec_jal_i | mini_dec_jalr_i | (mini_dec_branch_i & mini_dec_imm_i[XLEN-1]);
    npc_d = mini_dec_jalr_i ? jalr_tgt_d : (pred ? pc_q + mini_dec_imm_i : pc_q + XLEN'(4));
    jalr_stall = mini_dec_jalr_i & (mini_dec_jalr_rs1_idx_i != 5'd0) & jalr_rs1_busy_i;
    handoff = if_valid_o & id_ready_i;
  end
  assign imem_req_valid_o = state_q == REQ;
  assign imem_req_addr_o  = imem_req_valid_o ? pc_q : '0;
  assign mini_dec_instr_o = buf_q;
  assign jalr_rs1_idx_o   = state_q == JALR_WAIT ? idx_q : mini_dec_jalr_rs1_idx_i;
  // A redirect kills the instruction being presented in the same cycle.
  assign if_valid_o       = state_q == HOLD && !ex_redirect_i;
  assign if_instr_o       = if_valid_o ? buf_q : '0;
  assign if_pc_o          = if_valid_o ? pc_q : '0;
  assign if_pred_taken_o  = if_valid_o & pred;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      buf_q <= '0;
      idx_q <= '0;
      imm_q <= '0;
    end else if (ex_redirect_i) begin
      pc_q <= ex_redirect_pc_i;
      // A request still outstanding must have its response drained first.
      state_q <= (state_q == WAIT && !imem_rsp_valid_i) || (state_q == REQ && imem_req_ready_i) ||
                 state_q == DRAIN ? DRAIN : REQ;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: if (imem_req_ready_i) state_q <= WAIT;
        WAIT: if (imem_rsp_valid_i) begin
          buf_q <= imem_rsp_instr_i;
          state_q <= HOLD;
        end
        HOLD: if (handoff) begin
          if (jalr_stall) begin
            idx_q <= mini_dec_jalr_rs1_idx_i;
            imm_q <= mini_dec_imm_i;
            state_q <= JALR_WAIT;
          end else begin
            pc_q <= npc_d;
            state_q <= REQ;
          end
        end
        JALR_WAIT: if (!jalr_rs1_busy_i) begin
          pc_q <= wait_tgt_d;
          state_q <= REQ;
        end
        DRAIN: if (imem_rsp_valid_i) state_q <= REQ;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed self-checking bench for if_fetch_ctrl.
module tb_if_fetch_ctrl;
  logic clk_i = 0, rst_n_i = 0;
  logic imem_req_valid_o, imem_req_ready_i = 0;
  logic [31:0] imem_req_addr_o;
  logic imem_rsp_valid_i = 0;
  logic [31:0] imem_rsp_instr_i = 0, mini_dec_instr_o;
  logic mini_dec_jal_i = 0, mini_dec_jalr_i = 0, mini_dec_branch_i = 0;
  logic [4:0] mini_dec_jalr_rs1_idx_i = 0, jalr_rs1_idx_o;
  logic [31:0] mini_dec_imm_i = 0, jalr_rs1_rdata_i = 0;
  logic jalr_rs1_busy_i = 0, ex_redirect_i = 0;
  logic [31:0] ex_redirect_pc_i = 0;
  logic if_valid_o, id_ready_i = 1, if_pred_taken_o;
  logic [31:0] if_instr_o, if_pc_o;
  int tests = 0, fails = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  if_fetch_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_instr_i(imem_rsp_instr_i), .mini_dec_instr_o(mini_dec_instr_o),
    .mini_dec_jal_i(mini_dec_jal_i), .mini_dec_jalr_i(mini_dec_jalr_i),
    .mini_dec_branch_i(mini_dec_branch_i), .mini_dec_jalr_rs1_idx_i(mini_dec_jalr_rs1_idx_i),
    .mini_dec_imm_i(mini_dec_imm_i), .jalr_rs1_idx_o(jalr_rs1_idx_o),
    .jalr_rs1_rdata_i(jalr_rs1_rdata_i), .jalr_rs1_busy_i(jalr_rs1_busy_i),
    .ex_redirect_i(ex_redirect_i), .ex_redirect_pc_i(ex_redirect_pc_i),
    .if_valid_o(if_valid_o), .id_ready_i(id_ready_i), .if_instr_o(if_instr_o),
    .if_pc_o(if_pc_o), .if_pred_taken_o(if_pred_taken_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid_o && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("req_timeout", {31'd0, imem_req_valid_o}, 32'd1);
  endtask

  // One full transaction: accept, latency-1 response, decode flags in HOLD, handoff.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                       input logic jal, input logic jalr, input logic br,
                       input logic [31:0] imm, input logic [4:0] idx, input logic exp_pred);
    wait_req();
    chk({tag, "_addr"}, imem_req_addr_o, addr);
    imem_req_ready_i = 1;
    tick();
    imem_req_ready_i = 0;
    imem_rsp_valid_i = 1;
    imem_rsp_instr_i = instr;
    tick();
    imem_rsp_valid_i = 0;
    mini_dec_jal_i = jal;
    mini_dec_jalr_i = jalr;
    mini_dec_branch_i = br;
    mini_dec_imm_i = imm;
    mini_dec_jalr_rs1_idx_i = idx;
    id_ready_i = 1;
    #1;
    chk({tag, "_valid"}, {31'd0, if_valid_o}, 32'd1);
    chk({tag, "_instr"}, if_instr_o, instr);
    chk({tag, "_pc"}, if_pc_o, addr);
    chk({tag, "_pred"}, {31'd0, if_pred_taken_o}, {31'd0, exp_pred});
    tick();
    mini_dec_jal_i = 0;
    mini_dec_jalr_i = 0;
    mini_dec_branch_i = 0;
    mini_dec_imm_i = 0;
    mini_dec_jalr_rs1_idx_i = 0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    chk("rst_req_addr", imem_req_addr_o, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid_o}, 32'd0);
    chk("rst_if_pc", if_pc_o, 32'd0);
    chk("rst_mini_instr", mini_dec_instr_o, 32'd0);
    rst_n_i = 1;
    #1;
    chk("idle_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    tick();
    chk("first_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    chk("first_req_addr", imem_req_addr_o, 32'h8000_0000);
    fetch("nop0", 32'h8000_0000, NOP, 0, 0, 0, 32'd0, 5'd0, 0);
    fetch("nop1", 32'h8000_0004, NOP, 0, 0, 0, 32'd0, 5'd0, 0);
    fetch("nop2", 32'h8000_0008, NOP, 0, 0, 0, 32'd0, 5'd0, 0);
    fetch("jal", 32'h8000_000C, 32'h0100_006F, 1, 0, 0, 32'd16, 5'd0, 1);
    fetch("bbwd", 32'h8000_001C, 32'hFE00_0CE3, 0, 0, 1, 32'hFFFF_FFF8, 5'd0, 1);
    fetch("bfwd", 32'h8000_0014, 32'h0000_0463, 0, 0, 1, 32'd8, 5'd0, 0);
    jalr_rs1_rdata_i = 32'h8000_1000;
    jalr_rs1_busy_i = 1;
    fetch("jalr5", 32'h8000_0018, 32'h0032_8067, 0, 1, 0, 32'd3, 5'd5, 1);
    for (int i = 0; i < 3; i++) begin
      chk("jalr_wait_noreq", {31'd0, imem_req_valid_o}, 32'd0);
      chk("jalr_wait_idx", {27'd0, jalr_rs1_idx_o}, 32'd5);
      if (i == 2) jalr_rs1_busy_i = 0;
      tick();
    end
    chk("jalr_resume_valid", {31'd0, imem_req_valid_o}, 32'd1);
    jalr_rs1_rdata_i = 32'h1234_5678;
    jalr_rs1_busy_i = 1;
    fetch("jalr0", 32'h8000_1002, 32'h1010_0067, 0, 1, 0, 32'h0000_0101, 5'd0, 1);
    jalr_rs1_busy_i = 0;
    chk("jalr0_nostall", {31'd0, imem_req_valid_o}, 32'd1);
    chk("jalr0_addr", imem_req_addr_o, 32'h0000_0100);
    imem_req_ready_i = 1;
    tick();
    imem_req_ready_i = 0;
    ex_redirect_i = 1;
    ex_redirect_pc_i = 32'h8000_2000;
    #1;
    chk("redir_wait_ifvalid", {31'd0, if_valid_o}, 32'd0);
    tick();
    ex_redirect_i = 0;
    chk("drain_noreq", {31'd0, imem_req_valid_o}, 32'd0);
    tick();
    imem_rsp_valid_i = 1;
    imem_rsp_instr_i = 32'hDEAD_BEEF;
    #1;
    chk("drain_ifvalid", {31'd0, if_valid_o}, 32'd0);
    tick();
    imem_rsp_valid_i = 0;
    chk("drain_done_ifvalid", {31'd0, if_valid_o}, 32'd0);
    chk("drain_done_req", {31'd0, imem_req_valid_o}, 32'd1);
    chk("drain_done_addr", imem_req_addr_o, 32'h8000_2000);
    imem_req_ready_i = 1;
    tick();
    imem_req_ready_i = 0;
    imem_rsp_valid_i = 1;
    imem_rsp_instr_i = 32'hABCD_0013;
    id_ready_i = 0;
    tick();
    imem_rsp_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", {31'd0, if_valid_o}, 32'd1);
      chk("stall_instr", if_instr_o, 32'hABCD_0013);
      chk("stall_pc", if_pc_o, 32'h8000_2000);
      chk("stall_noreq", {31'd0, imem_req_valid_o}, 32'd0);
      tick();
    end
    id_ready_i = 1;
    ex_redirect_i = 1;
    ex_redirect_pc_i = 32'h8000_3000;
    #1;
    chk("redir_hold_ifvalid", {31'd0, if_valid_o}, 32'd0);
    tick();
    ex_redirect_i = 0;
    chk("redir_hold_req", {31'd0, imem_req_valid_o}, 32'd1);
    chk("redir_hold_addr", imem_req_addr_o, 32'h8000_3000);
    imem_req_ready_i = 1;
    tick();
    imem_req_ready_i = 0;
    rst_n_i = 0;
    tick();
    chk("mid_rst_req", {31'd0, imem_req_valid_o}, 32'd0);
    chk("mid_rst_ifvalid", {31'd0, if_valid_o}, 32'd0);
    chk("mid_rst_addr", imem_req_addr_o, 32'd0);
    chk("mid_rst_mini", mini_dec_instr_o, 32'd0);
    rst_n_i = 1;
    imem_rsp_valid_i = 1;
    imem_rsp_instr_i = 32'hCAFE_BABE;
    tick();
    imem_rsp_valid_i = 0;
    chk("post_rst_ifvalid", {31'd0, if_valid_o}, 32'd0);
    fetch("post_rst", 32'h8000_0000, NOP, 0, 0, 0, 32'd0, 5'd0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
